// File: rtl/cla_pkg.sv
// rtl/cla_pkg.sv - shared FSM state type and slice width for the multicycle CLA adder
package cla_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/carry_look_ahead_4bit.sv
// rtl/carry_look_ahead_4bit.sv - 4-bit carry look-ahead adder slice
module carry_look_ahead_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c_in,
    output logic [3:0] sum,
    output logic       c_out
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g = a & b;
    assign p = a ^ b;

    // Every carry is a flat sum of products of c_in, g and p; no ripple chain.
    assign c[0] = c_in;
    assign c[1] = g[0] | (p[0] & c_in);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_in);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c_in);

    assign sum   = p ^ c[3:0];
    assign c_out = c[4];

endmodule

// File: rtl/cla_multicycle_adder.sv
// rtl/cla_multicycle_adder.sv - WIDTH-bit adder evaluated one 4-bit CLA slice per cycle
module cla_multicycle_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);

    localparam int NSLICE = WIDTH / SLICE_W;
    localparam int CNT_W  = $clog2(NSLICE);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NSLICE - 1);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               carry;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;

    logic [SLICE_W-1:0] slice_a;
    logic [SLICE_W-1:0] slice_b;
    logic [SLICE_W-1:0] slice_sum;
    logic               slice_c;
    logic [WIDTH-1:0]   sum_next;

    // Constant-index mux keeps the slice select and write-back free of variable part-selects.
    always_comb begin
        slice_a  = '0;
        slice_b  = '0;
        sum_next = sum;
        for (int k = 0; k < NSLICE; k++) begin
            if (cnt == CNT_W'(k)) begin
                slice_a = a_q[k*SLICE_W +: SLICE_W];
                slice_b = b_q[k*SLICE_W +: SLICE_W];
                sum_next[k*SLICE_W +: SLICE_W] = slice_sum;
            end
        end
    end

    carry_look_ahead_4bit u_cla (
        .a     (slice_a),
        .b     (slice_b),
        .c_in  (carry),
        .sum   (slice_sum),
        .c_out (slice_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            sum       <= '0;
            c_out     <= 1'b0;
            ovf       <= 1'b0;
            cnt       <= '0;
            carry     <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q      <= a;
                        b_q      <= b;
                        carry    <= c_in;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    sum   <= sum_next;
                    carry <= slice_c;
                    if (cnt == LAST) begin
                        c_out     <= slice_c;
                        // The top slice's sum MSB is the final sum MSB.
                        ovf       <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                                     (slice_sum[SLICE_W-1] != a_q[WIDTH-1]);
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/cla_multicycle_adder.md
CLA_MULTICYCLE_ADDER -- requirements
Module: cla_multicycle_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand width in bits; legal values are multiples of 4, minimum 8.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid, input, 1: the a, b and c_in inputs are presented.
REQ-005 SHALL have port in_ready, output, 1: the block can accept a new operation.
REQ-006 SHALL have port a, input, WIDTH: operand A.
REQ-007 SHALL have port b, input, WIDTH: operand B.
REQ-008 SHALL have port c_in, input, 1: carry into bit 0.
REQ-009 SHALL have port out_valid, output, 1: sum, c_out and ovf are valid.
REQ-010 SHALL have port out_ready, input, 1: the consumer accepts the result.
REQ-011 SHALL have port sum, output, WIDTH: a + b + c_in, modulo 2^WIDTH.
REQ-012 SHALL have port c_out, output, 1: unsigned carry out of the MSB.
REQ-013 SHALL have port ovf, output, 1: two's-complement overflow.

Function
REQ-014 SHALL implement a three-state FSM with states IDLE, CALC and DONE.
REQ-015 SHALL assert in_ready only in IDLE; out_valid SHALL be asserted only in DONE; all outputs SHALL be registered.
REQ-016 SHALL accept an operation on a clock edge with in_valid=1 in IDLE: latch a, b and c_in, clear the slice counter, load the carry register with c_in, and go to CALC.
REQ-017 SHALL, on each CALC cycle, add the current 4-bit slice (slice index = counter, LSB slice first) through one 4-bit CLA.
REQ-018 SHALL, on each CALC cycle, write that slice's sum nibble into sum[4k+3:4k] and store the slice carry-out in the carry register, which becomes the next slice's carry-in.
REQ-019 SHALL stay in CALC for exactly WIDTH/4 cycles, then go to DONE; out_valid SHALL rise WIDTH/4 cycles after the accepting edge (4 cycles for WIDTH=16).
REQ-020 SHALL, on the last slice, register c_out = final slice carry-out and ovf = (a[MSB]==b[MSB]) && (sum[MSB]!=a[MSB]).
REQ-021 SHALL, in DONE, hold sum, c_out and ovf stable until out_ready=1; on that edge it SHALL go to IDLE and deassert out_valid.
REQ-022 SHALL ignore in_valid, a, b and c_in while in CALC or DONE; latched operands SHALL be unaffected.
REQ-023 SHALL, with out_ready held high, keep out_valid high for exactly one cycle; the earliest next accept is on the following cycle (one result per WIDTH/4+2 cycles).
REQ-024 SHALL keep the slice counter sized ceil(log2(WIDTH/4)) bits, and it SHALL NOT wrap within an operation.
REQ-025 SHALL retain sum, c_out and ovf after leaving DONE until the next result is written.

Reset
REQ-026 SHALL, on rst_n=0 and regardless of clk: state=IDLE, in_ready=1, out_valid=0, sum=0, c_out=0, ovf=0, counter=0, carry register=0, operand registers=0.
REQ-027 SHALL, on reset mid-CALC or in DONE, abort the operation with no result produced; the first accept is possible on the first edge after rst_n rises.

Structure
REQ-028 SHALL place the state enumeration and the SLICE_W=4 constant in shared package cla_pkg.
REQ-029 SHALL instantiate exactly one existing carry_look_ahead_4bit sub-module as the per-slice adder; there SHALL be no other arithmetic on the sum path.

Verification
REQ-030 SHALL cover: WIDTH=16, a=0x1234, b=0x4321, c_in=0 -> out_valid 4 cycles after accept, sum=0x5555, c_out=0, ovf=0.
REQ-031 SHALL cover: a=0xFFFF, b=0x0001, c_in=0 -> sum=0x0000, c_out=1, ovf=0 (carry ripples through all four slices).
REQ-032 SHALL cover: a=0x7FFF, b=0x0000, c_in=1 -> sum=0x8000, c_out=0, ovf=1.
REQ-033 SHALL cover: a=0x00F0, b=0x0010, c_in=0 with out_ready=0 for 3 cycles in DONE -> sum=0x0100 held stable; in_ready=0 throughout; IDLE on the edge where out_ready=1.
REQ-034 SHALL cover: a second in_valid pulse (a=0xAAAA) during CALC -> ignored, and the first result is unchanged.
REQ-035 SHALL cover: rst_n low during cycle 2 of CALC -> immediately out_valid=0, sum=0, in_ready=1; a new op after release completes correctly.
